// File: rtl/cpu_seq_if.sv
// Datapath-facing bus of the multi-cycle sequencer: ROM/PC inputs, decode
// inputs from ctrlunit/branch, and the write strobes back to the datapath.
// Signal suffixes give the direction as seen by the sequencer (slave).
interface cpu_seq_if #(
    parameter int unsigned PC_W = 5,
    parameter int unsigned IW   = 8
);
    logic [IW-1:0]   ins_i;
    logic [PC_W-1:0] pc_i;
    logic [IW-1:0]   ir_o;
    logic            ctrl_wr_i;
    logic            ctrl_wm_i;
    logic            branch_i;
    logic            pc_inc_o;
    logic            pc_load_o;
    logic            acc_we_o;
    logic            ram_we_o;

    // Datapath side.
    modport master (
        output ins_i, pc_i, ctrl_wr_i, ctrl_wm_i, branch_i,
        input  ir_o, pc_inc_o, pc_load_o, acc_we_o, ram_we_o
    );

    // Sequencer side.
    modport slave (
        input  ins_i, pc_i, ctrl_wr_i, ctrl_wm_i, branch_i,
        output ir_o, pc_inc_o, pc_load_o, acc_we_o, ram_we_o
    );
endinterface

// File: rtl/cpu_seq.sv
// cpu_seq: FETCH/DECODE/EXEC/WB sequencer for the 8-bit accumulator CPU.
// Owns the instruction register, the PC/ACC/RAM write strobes, run/halt/step
// debug control and a retired-instruction counter.
// Optional feature macro: CPU_SEQ_BREAKPOINT_EN adds a PC breakpoint checked
// at WB against the next PC.
module cpu_seq #(
    parameter int unsigned PC_W  = 5,
    parameter int unsigned IW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             step_req_i,
    output logic             step_ack_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [2:0]       state_o,
`ifdef CPU_SEQ_BREAKPOINT_EN
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    output logic             bp_hit_o,
`endif
    cpu_seq_if.slave         bus
);

    typedef enum logic [2:0] {
        StHalt   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stepping_q, stepping_d;
    logic             step_req_q;
    logic             step_edge_q;
    logic             bp_hit;

`ifdef CPU_SEQ_BREAKPOINT_EN
    logic [PC_W-1:0]  next_pc;

    // Address the PC will hold after this WB; only meaningful in WB.
    always_comb begin
        next_pc = bus.branch_i ? bus.ir_o[PC_W-1:0] : bus.pc_i + PC_W'(1);
        bp_hit  = (state_q == StWb) && bp_en_i && (next_pc == bp_addr_i);
    end

    assign bp_hit_o = bp_hit;
`else
    logic [PC_W-1:0]  unused_pc;

    assign unused_pc = bus.pc_i;
    assign bp_hit    = 1'b0;
`endif

    // State, IR, counter, stepping flag and step-edge register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StHalt;
            ir_q        <= '0;
            cnt_q       <= '0;
            stepping_q  <= 1'b0;
            step_req_q  <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            stepping_q  <= stepping_d;
            step_req_q  <= step_req_i;
            // One-cycle pulse; only HALT looks at it, so edges elsewhere are lost.
            step_edge_q <= step_req_i & ~step_req_q;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        cnt_d         = cnt_q;
        stepping_d    = stepping_q;
        bus.pc_inc_o  = 1'b0;
        bus.pc_load_o = 1'b0;
        bus.acc_we_o  = 1'b0;
        bus.ram_we_o  = 1'b0;
        step_ack_o    = 1'b0;

        case (state_q)
            StHalt: begin
                if (run_i) begin
                    state_d = StFetch;
                end else if (step_edge_q) begin
                    state_d    = StFetch;
                    stepping_d = 1'b1;
                end
            end
            StFetch: begin
                ir_d    = bus.ins_i;
                state_d = StDecode;
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                bus.ram_we_o = bus.ctrl_wm_i;
                state_d      = StWb;
            end
            StWb: begin
                bus.acc_we_o  = bus.ctrl_wr_i;
                bus.pc_load_o = bus.branch_i;
                bus.pc_inc_o  = ~bus.branch_i;
                cnt_d         = cnt_q + CNT_W'(1);
                step_ack_o    = stepping_q;
                stepping_d    = 1'b0;
                state_d       = (run_i && !stepping_q && !bp_hit) ? StFetch : StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    assign bus.ir_o    = ir_q;
    assign instr_cnt_o = cnt_q;
    assign state_o     = state_q;
    assign halt_o      = (state_q == StHalt);

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Multi-cycle instruction sequencer for the 8-bit accumulator CPU. It replaces free-running single-cycle execution with a FETCH/DECODE/EXEC/WB state machine. It owns the instruction register and the write strobes for the PC, accumulator and RAM, and adds debug run/halt/single-step control plus a retired-instruction counter. Decoding stays in `ctrlunit` and branch resolution stays in `branch`; `cpu_seq` only decides *when* their outputs take effect.

## Interface
- `PC_W`, 5: program-counter / jump-address width.
- `IW`, 8: instruction width; opcode is `[IW-1:IW-3]`, address is `[PC_W-1:0]`.
- `CNT_W`, 16: retired-instruction counter width.

- `clk_i`, in, 1: the single clock; all state updates on its rising edge.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `run_i`, in, 1: level; 1 = free-run, 0 = halt after the current instruction.
- `step_req_i`, in, 1: single-step request; acts on its rising edge.
- `step_ack_o`, out, 1: 1-cycle pulse in the WB cycle of a stepped instruction.
- `halt_o`, out, 1: 1 while in the HALT state.
- `ins_i`, in, IW: ROM data at the current PC.
- `pc_i`, in, PC_W: current PC value.
- `ir_o`, out, IW: instruction register, which feeds `ctrlunit`, `branch`, `alu` and the RAM address.
- `ctrl_wr_i`, in, 1: accumulator-write decode from `ctrlunit`.
- `ctrl_wm_i`, in, 1: memory-write decode from `ctrlunit`.
- `branch_i`, in, 1: jump-taken output from `branch`.
- `pc_inc_o`, out, 1: PC increment strobe.
- `pc_load_o`, out, 1: PC load strobe (target is `ir_o[PC_W-1:0]`).
- `acc_we_o`, out, 1: accumulator write enable.
- `ram_we_o`, out, 1: RAM write enable.
- `instr_cnt_o`, out, CNT_W: count of retired instructions.
- `state_o`, out, 3: current state encoding.
- `bp_en_i`, in, 1: breakpoint enable (BREAKPOINT_EN builds only).
- `bp_addr_i`, in, PC_W: breakpoint address (BREAKPOINT_EN builds only).
- `bp_hit_o`, out, 1: breakpoint-hit pulse (BREAKPOINT_EN builds only).

## Operation
- State encodings: HALT=0, FETCH=1, DECODE=2, EXEC=3, WB=4. Codes 5–7 are illegal and go to HALT on the next edge.
- HALT:
  - If `run_i`=1, go to FETCH.
  - Otherwise, on a registered rising edge of `step_req_i`, go to FETCH and set the internal `stepping` flag.
  - If `run_i` and a step edge occur in the same cycle, run wins and the step edge is discarded.
  - Step edges seen outside HALT are discarded.
- FETCH: `ir_o` <= `ins_i`; go to DECODE.
- DECODE: no strobes; lets the decode from `ctrlunit`/`branch` settle on the new `ir_o`. Go to EXEC.
- EXEC: `ram_we_o` = `ctrl_wm_i`; go to WB.
- WB:
  - `acc_we_o` = `ctrl_wr_i`.
  - `pc_load_o` = `branch_i`; `pc_inc_o` = !`branch_i`. Exactly one of the two is high.
  - `instr_cnt_o` increments.
  - `step_ack_o` = `stepping`; `stepping` then clears.
  - Next state is FETCH if `run_i`=1 and `stepping`=0 and no breakpoint hit; otherwise HALT.
- `run_i` falling mid-instruction never aborts the instruction. It completes through WB, then the sequencer enters HALT.
- `instr_cnt_o` wraps from 2^CNT_W−1 to 0.
- All strobes are combinational from the state register and the decode inputs. They are zero in every state other than the one listed above.

## Timing
- Each instruction takes 4 cycles (FETCH→WB); throughput is 1 instruction per 4 clocks in free-run.
- HALT→FETCH takes 1 cycle after `run_i`=1 is sampled. A step adds 1 cycle for edge registration.
- Reset values (asserted asynchronously, held until the rising edge after `rst_ni` deasserts):
  - state=HALT, `halt_o`=1, `ir_o`=0, `instr_cnt_o`=0.
  - `stepping`=0, step edge register=0.
  - All strobes, `step_ack_o` and `bp_hit_o` are 0.
- Reset during any state discards the in-flight instruction. Any write already strobed is not undone.
- `ram_we_o` and `acc_we_o` are never high in the same cycle.

## Configuration
- `CPU_SEQ_BREAKPOINT_EN` defined:
  - In WB, compute next PC = `branch_i` ? `ir_o[PC_W-1:0]` : `pc_i`+1 (mod 2^PC_W, so 31 wraps to 0).
  - If `bp_en_i`=1 and next PC equals `bp_addr_i`, pulse `bp_hit_o` and go to HALT regardless of `run_i`.
  - Resuming from HALT executes the instruction at the breakpoint address without re-triggering, because the check runs only at WB.
- Not defined: the `bp_*` ports are absent and the sequencer never halts on an address.

## Test plan
- Reset and free-run: `rst_ni` low, then high with `run_i`=1 → `halt_o` drops 1 cycle later; `pc_inc_o` pulses every 4th cycle; `instr_cnt_o`=3 after 13 cycles.
- Store: IR loads a store op (`ctrl_wm_i`=1, `ctrl_wr_i`=0) → `ram_we_o`=1 only in EXEC; `acc_we_o`=0 for the whole instruction.
- Jump: `branch_i`=1, IR address field 0x1A → `pc_load_o`=1 and `pc_inc_o`=0 in WB. With `pc_i`=31 and `branch_i`=0 → `pc_inc_o`=1 in WB; breakpoint builds compute next PC=0.
- Step: `run_i`=0, `step_req_i` held high for 10 cycles → exactly one instruction executes; `step_ack_o` pulses once; the second step requires `step_req_i` to go low then high again.
- Run drop: `run_i` falls during DECODE → WB still strobes, `instr_cnt_o` increments by 1, then HALT.
- Breakpoint (`CPU_SEQ_BREAKPOINT_EN`): `bp_en_i`=1, `bp_addr_i`=5, straight-line code from 0 → HALT after 5 instructions with `bp_hit_o` pulsed once. Raising `run_i` again executes address 5 without halting.
